// File: rtl/odd_issue_ctrl.sv
// rtl/odd_issue_ctrl.sv - odd-pipe issue scheduler, RAW scoreboard and forwarding-select generator
module odd_issue_ctrl #(
    parameter int LAT_PERM = 4,
    parameter int LAT_LS   = 6,
    parameter int LAT_BR   = 1,
    parameter int DEPTH    = 7,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_unit,
    input  logic [6:0]       in_rt_addr,
    input  logic             in_reg_write,
    input  logic [6:0]       in_ra_addr,
    input  logic [6:0]       in_rb_addr,
    input  logic             in_ra_used,
    input  logic             in_rb_used,
    input  logic             flush,
    output logic             issue_valid,
    output logic [1:0]       issue_unit,
    output logic [6:0]       issue_rt_addr,
    output logic             issue_reg_write,
    output logic [2:0]       issue_ra_fwd,
    output logic [2:0]       issue_rb_fwd,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic       hold_v;
    logic [1:0] hold_unit;
    logic [6:0] hold_rt;
    logic       hold_rw;
    logic [6:0] hold_ra;
    logic [6:0] hold_rb;
    logic       hold_ra_used;
    logic       hold_rb_used;
    logic [2:0] hold_lat;

    // Scoreboard slot index is the producer's age relative to its issue_* cycle.
    logic [DEPTH-1:0]      sb_v;
    logic [DEPTH-1:0][6:0] sb_addr;
    logic [DEPTH-1:0][2:0] sb_lat;

    logic       ra_haz, rb_haz, hazard, go, load;
    logic [2:0] ra_fwd, rb_fwd;

    // Oldest-to-youngest scan so the youngest matching producer decides.
    function automatic logic [3:0] eval_src(input logic used, input logic [6:0] addr,
                                            input logic [DEPTH-1:0] v,
                                            input logic [DEPTH-1:0][6:0] a_tab,
                                            input logic [DEPTH-1:0][2:0] l_tab);
        logic       haz;
        logic [2:0] fwd;
        logic [2:0] age_next;
        haz = 1'b0;
        fwd = 3'd0;
        if (used) begin
            for (int a = DEPTH - 1; a >= 0; a--) begin
                age_next = 3'(a + 1);
                if (v[a] && a_tab[a] == addr) begin
                    if (age_next >= l_tab[a]) begin
                        haz = 1'b0;
                        fwd = age_next;
                    end else begin
                        haz = 1'b1;
                        fwd = 3'd0;
                    end
                end
            end
        end
        return {haz, fwd};
    endfunction

    always_comb begin
        {ra_haz, ra_fwd} = eval_src(hold_ra_used, hold_ra, sb_v, sb_addr, sb_lat);
        {rb_haz, rb_fwd} = eval_src(hold_rb_used, hold_rb, sb_v, sb_addr, sb_lat);
        hazard   = ra_haz | rb_haz;
        go       = hold_v & ~hazard & ~flush;
        stall    = hold_v & hazard & ~flush;
        in_ready = ~flush & (~hold_v | go);
        load     = in_valid & in_ready;
        case (hold_unit)
            2'd1:    hold_lat = 3'(LAT_LS);
            2'd2:    hold_lat = 3'(LAT_BR);
            default: hold_lat = 3'(LAT_PERM);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v          <= 1'b0;
            hold_unit       <= 2'd0;
            hold_rt         <= 7'd0;
            hold_rw         <= 1'b0;
            hold_ra         <= 7'd0;
            hold_rb         <= 7'd0;
            hold_ra_used    <= 1'b0;
            hold_rb_used    <= 1'b0;
            sb_v            <= '0;
            sb_addr         <= '0;
            sb_lat          <= '0;
            issue_valid     <= 1'b0;
            issue_unit      <= 2'd0;
            issue_rt_addr   <= 7'd0;
            issue_reg_write <= 1'b0;
            issue_ra_fwd    <= 3'd0;
            issue_rb_fwd    <= 3'd0;
            stall_cnt       <= '0;
        end else begin
            if (flush) begin
                hold_v <= 1'b0;
            end else if (load) begin
                hold_v       <= 1'b1;
                hold_unit    <= in_unit;
                hold_rt      <= in_rt_addr;
                hold_rw      <= in_reg_write;
                hold_ra      <= in_ra_addr;
                hold_rb      <= in_rb_addr;
                hold_ra_used <= in_ra_used;
                hold_rb_used <= in_rb_used;
            end else if (go) begin
                hold_v <= 1'b0;
            end

            for (int a = 1; a < DEPTH; a++) begin
                sb_v[a]    <= sb_v[a-1];
                sb_addr[a] <= sb_addr[a-1];
                sb_lat[a]  <= sb_lat[a-1];
            end
            sb_v[0]    <= go & hold_rw;
            sb_addr[0] <= hold_rt;
            sb_lat[0]  <= hold_lat;

            issue_valid     <= go;
            issue_unit      <= go ? hold_unit : 2'd0;
            issue_rt_addr   <= go ? hold_rt : 7'd0;
            issue_reg_write <= go & hold_rw;
            issue_ra_fwd    <= go ? ra_fwd : 3'd0;
            issue_rb_fwd    <= go ? rb_fwd : 3'd0;

            if (stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// tb/tb_odd_issue_ctrl.sv - directed self-checking bench for odd_issue_ctrl
module tb_odd_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_unit = 2'd0;
    logic [6:0]  in_rt_addr = 7'd0;
    logic        in_reg_write = 1'b0;
    logic [6:0]  in_ra_addr = 7'd0;
    logic [6:0]  in_rb_addr = 7'd0;
    logic        in_ra_used = 1'b0;
    logic        in_rb_used = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid;
    logic [1:0]  issue_unit;
    logic [6:0]  issue_rt_addr;
    logic        issue_reg_write;
    logic [2:0]  issue_ra_fwd;
    logic [2:0]  issue_rb_fwd;
    logic        stall;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad = 0;

    odd_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_unit(in_unit), .in_rt_addr(in_rt_addr), .in_reg_write(in_reg_write),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
        .in_ra_used(in_ra_used), .in_rb_used(in_rb_used),
        .flush(flush),
        .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_rt_addr(issue_rt_addr), .issue_reg_write(issue_reg_write),
        .issue_ra_fwd(issue_ra_fwd), .issue_rb_fwd(issue_rb_fwd),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] unit, input logic [6:0] rt, input logic rw,
                        input logic [6:0] ra, input logic rau,
                        input logic [6:0] rb, input logic rbu);
        in_valid     = 1'b1;
        in_unit      = unit;
        in_rt_addr   = rt;
        in_reg_write = rw;
        in_ra_addr   = ra;
        in_ra_used   = rau;
        in_rb_addr   = rb;
        in_rb_used   = rbu;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        flush = 1'b0;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        check("rst_issue_valid", issue_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall", stall, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_rt", issue_rt_addr, 0);

        // independent stream r1<-r2, r3<-r4, r5<-r6
        send(2'd0, 7'd1, 1'b1, 7'd2, 1'b1, 7'd0, 1'b0); cyc();
        send(2'd0, 7'd3, 1'b1, 7'd4, 1'b1, 7'd0, 1'b0); cyc();
        check("ind0_valid", issue_valid, 1);
        check("ind0_rt", issue_rt_addr, 1);
        check("ind0_fwd", issue_ra_fwd, 0);
        send(2'd0, 7'd5, 1'b1, 7'd6, 1'b1, 7'd0, 1'b0); cyc();
        check("ind1_valid", issue_valid, 1);
        check("ind1_rt", issue_rt_addr, 3);
        idle(); cyc();
        check("ind2_valid", issue_valid, 1);
        check("ind2_rt", issue_rt_addr, 5);
        check("ind2_fwd", issue_ra_fwd, 0);
        check("ind2_rw", issue_reg_write, 1);
        check("ind_stall_cnt", stall_cnt, 0);
        cyc();
        check("ind_drain_valid", issue_valid, 0);
        check("ind_drain_rw", issue_reg_write, 0);

        // Perm r5 -> consumer ra=r5: 3 stall cycles, presents at c+4 with fwd=4
        do_reset();
        send(2'd0, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0); cyc();
        send(2'd0, 7'd7, 1'b0, 7'd5, 1'b1, 7'd0, 1'b0); cyc();
        check("perm_c_valid", issue_valid, 1);
        check("perm_c_rt", issue_rt_addr, 5);
        check("perm_c_stall", stall, 1);
        idle();
        cyc(); check("perm_c1_stall", stall, 1);
        cyc(); check("perm_c2_stall", stall, 1);
        cyc(); check("perm_c3_stall", stall, 0);
        check("perm_c3_valid", issue_valid, 0);
        cyc();
        check("perm_c4_valid", issue_valid, 1);
        check("perm_c4_rt", issue_rt_addr, 7);
        check("perm_c4_ra_fwd", issue_ra_fwd, 4);
        check("perm_stall_cnt", stall_cnt, 3);

        // LS r9 -> consumer rb=r9: 5 stalls, presents c+6 with fwd=6
        do_reset();
        send(2'd1, 7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0); cyc();
        send(2'd0, 7'd10, 1'b0, 7'd9, 1'b0, 7'd9, 1'b1); cyc();
        check("ls_c_unit", issue_unit, 1);
        check("ls_c_stall", stall, 1);
        idle();
        for (int i = 1; i <= 4; i++) begin
            cyc(); check($sformatf("ls_c%0d_stall", i), stall, 1);
        end
        cyc(); check("ls_c5_stall", stall, 0);
        cyc();
        check("ls_c6_valid", issue_valid, 1);
        check("ls_c6_rb_fwd", issue_rb_fwd, 6);
        check("ls_c6_ra_fwd", issue_ra_fwd, 0);
        check("ls_stall_cnt", stall_cnt, 5);
        send(2'd0, 7'd11, 1'b0, 7'd9, 1'b1, 7'd0, 1'b0); cyc();
        check("ls_c7_valid", issue_valid, 0);
        idle(); cyc();
        check("ls_c8_stall", stall, 0);
        check("ls_c8_valid", issue_valid, 1);
        check("ls_c8_rt", issue_rt_addr, 11);
        check("ls_c8_ra_fwd", issue_ra_fwd, 0);

        // youngest match: Perm r5 at c, Br r5 at c+1, consumer ra=r5
        do_reset();
        send(2'd0, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0); cyc();
        send(2'd2, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0); cyc();
        check("ym_c_stall", stall, 0);
        send(2'd0, 7'd8, 1'b0, 7'd5, 1'b1, 7'd0, 1'b0); cyc();
        check("ym_c1_unit", issue_unit, 2);
        check("ym_c1_stall", stall, 0);
        idle(); cyc();
        check("ym_c2_valid", issue_valid, 1);
        check("ym_c2_rt", issue_rt_addr, 8);
        check("ym_c2_ra_fwd", issue_ra_fwd, 1);
        check("ym_stall_cnt", stall_cnt, 0);

        // unused source never hazards
        do_reset();
        send(2'd0, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0); cyc();
        send(2'd0, 7'd8, 1'b0, 7'd5, 1'b0, 7'd5, 1'b0); cyc();
        check("unused_stall", stall, 0);
        idle(); cyc();
        check("unused_valid", issue_valid, 1);
        check("unused_ra_fwd", issue_ra_fwd, 0);
        check("unused_rb_fwd", issue_rb_fwd, 0);

        // flush while stalled with a new instruction offered
        do_reset();
        send(2'd0, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0); cyc();
        send(2'd0, 7'd7, 1'b0, 7'd5, 1'b1, 7'd0, 1'b0); cyc();
        check("fl_pre_stall", stall, 1);
        send(2'd0, 7'd12, 1'b1, 7'd13, 1'b1, 7'd0, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_in_ready", in_ready, 0);
        check("fl_stall", stall, 0);
        cyc();
        flush = 1'b0;
        idle();
        #1;
        check("fl_next_valid", issue_valid, 0);
        check("fl_next_ready", in_ready, 1);
        check("fl_next_stall", stall, 0);
        cyc();
        check("fl_after_valid", issue_valid, 0);
        check("fl_stall_cnt", stall_cnt, 0);

        // reset during 2nd stall cycle
        do_reset();
        send(2'd0, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0); cyc();
        send(2'd0, 7'd7, 1'b0, 7'd5, 1'b1, 7'd0, 1'b0); cyc();
        idle(); cyc();
        check("rs_stall2", stall, 1);
        check("rs_cnt_pre", stall_cnt, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        check("rs_valid", issue_valid, 0);
        check("rs_unit", issue_unit, 0);
        check("rs_rt", issue_rt_addr, 0);
        check("rs_rw", issue_reg_write, 0);
        check("rs_fwd", {issue_ra_fwd, issue_rb_fwd}, 0);
        check("rs_stall", stall, 0);
        check("rs_cnt", stall_cnt, 0);
        check("rs_ready", in_ready, 1);
        send(2'd0, 7'd7, 1'b0, 7'd5, 1'b1, 7'd0, 1'b0); cyc();
        check("rs_resend_stall", stall, 0);
        idle(); cyc();
        check("rs_resend_valid", issue_valid, 1);
        check("rs_resend_fwd", issue_ra_fwd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/odd_issue_ctrl.md
Name: odd_issue_ctrl

Overview:
- Issue scheduler and scoreboard sitting directly in front of the odd pipe (Permute / LocalStore / Branch units feeding a 7-stage forwarding shift chain into rt_wb).
- Accepts one decoded odd-pipe instruction per cycle through a valid/ready handshake and holds it in a single-entry holding register.
- Stalls the instruction on RAW hazards against in-flight odd-pipe results.
- Drives the RF/FWD-stage issue signals together with per-source forwarding selects (which fw stage supplies ra/rb).

Parameters:
- LAT_PERM, 4, stage at which a Permute result enters the forwarding chain.
- LAT_LS, 6, stage at which a LocalStore result enters the forwarding chain.
- LAT_BR, 1, stage at which a Branch (link) result enters the forwarding chain.
- DEPTH, 7, forwarding stages before the RF write (rt_wb at age 7).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  controller can accept an instruction this cycle
- in_unit  in  2  0 Perm, 1 LS, 2 Br, 3 undefined (treated as Perm)
- in_rt_addr  in  7  destination register
- in_reg_write  in  1  instruction writes rt
- in_ra_addr, in_rb_addr  in  7 each  source registers
- in_ra_used, in_rb_used  in  1 each  source is actually read
- flush  in  1  discard the holding-register instruction
- issue_valid  out  1  instruction presented to the odd pipe this cycle
- issue_unit  out  2  unit of the presented instruction
- issue_rt_addr  out  7  destination of the presented instruction
- issue_reg_write  out  1  reg_write of the presented instruction (0 when issue_valid=0)
- issue_ra_fwd, issue_rb_fwd  out  3 each  0 = register file; k in 1..7 = fw stage k (7 = rt_wb)
- stall  out  1  holding register valid and blocked by a hazard
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: all outputs 0 except in_ready=1; holding register and scoreboard cleared; any in-flight state is discarded, including on reset during a stall.
- Holding register:
  - in_ready = !hold_v | go.
  - Load on in_valid & in_ready.
  - Clear on go with no new load.
  - flush clears hold_v, forces go=0 and takes priority over a simultaneous load (in_ready=0 during flush).
- Scoreboard: DEPTH entries indexed by age, each {v, addr, lat}.
  - Each cycle every entry ages by 1; the age-7 entry drops.
  - On go with reg_write=1, a new entry at age 0 is valid on the issue_* cycle, with lat chosen from the unit.
- Hazard eval for the cycle-t holding instruction (would present at t+1), per used source:
  - Find the youngest valid entry with a matching address; its age at t+1 is a' = age+1.
  - If no match: fwd=0.
  - If a' >= lat: fwd=a'.
  - Else: hazard.
  - Only the youngest match matters; older matches are ignored.
- Other hazard rules:
  - Unused sources never hazard and get fwd=0.
  - Address 0 is not special.
  - No structural hazard exists, because all results reach stage 7 at fixed age.
- Timing:
  - go = hold_v & !hazard & !flush.
  - issue_* registered from go: presented at t+1 with issue_valid=1.
  - issue_valid=0 and issue_reg_write=0 when no go.
- Stall:
  - stall = hold_v & hazard & !flush (combinational).
  - stall_cnt increments by 1 on each stall cycle and saturates at all-ones.
- Issue rate and stall lengths:
  - Throughput is 1 instruction/cycle with no hazards.
  - A dependent consumer presents exactly lat cycles after its producer presents.

Test Plan:
- Independent stream: 3 Perm instrs (r1<-r2, r3<-r4, r5<-r6) on consecutive in_valid -> issue_valid 3 consecutive cycles, all fwd=0, stall_cnt=0.
- Perm r5 presented at cycle c, consumer ra=r5 queued behind -> stall high 3 cycles, consumer presented at c+4 with issue_ra_fwd=4, stall_cnt=3.
- LS r9 at c, consumer rb=r9 -> consumer presented at c+6, issue_rb_fwd=6, stall_cnt=5; a consumer of r9 arriving at c+8 -> fwd=0.
- Youngest-match priority: Perm r5 at c, Br r5 at c+1, consumer ra=r5 -> presented c+2, issue_ra_fwd=1, no stall; and ra=r5 with ra_used=0 after Perm r5 -> no stall, fwd=0.
- Flush while a consumer is stalled with in_valid=1 -> hold cleared, no issue that cycle, in_ready=0 that cycle, in_ready=1 the next cycle.
- Reset asserted during a 2nd stall cycle -> next cycle all issue_* = 0, stall=0, stall_cnt=0, in_ready=1; a re-sent consumer of r5 issues with fwd=0 and no stall.
